fsm_rr_arbiter: RTL and testbench

//  Four-agent round-robin arbiter for the shared resource behind the fsm_full grant interface.
//  It replaces fixed priority with a rotating priority pointer and a bounded tenure.

---
 rtl/fsm_rr_arbiter.sv | 124 ++++++++++++
 tb/tb_fsm_rr_arbiter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/fsm_rr_arbiter.sv
// Four-agent round-robin arbiter with registered one-hot grants, bounded tenure
// (forced preemption after MAX_HOLD cycles) and a mandatory idle cycle between owners.
module fsm_rr_arbiter #(
   parameter int MAX_HOLD = 8,  // 0 disables preemption; must not exceed 2**HOLD_W-1
   parameter int HOLD_W   = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       req_0,
   input  logic       req_1,
   input  logic       req_2,
   input  logic       req_3,
   output logic       gnt_0,
   output logic       gnt_1,
   output logic       gnt_2,
   output logic       gnt_3,
   output logic [1:0] owner,
   output logic       busy,
   output logic       preempt,
   output logic       dbg_state
);

   localparam logic ST_IDLE  = 1'b0;
   localparam logic ST_GRANT = 1'b1;

   localparam logic              HOLD_LIMITED = (MAX_HOLD != 0);
   localparam logic [HOLD_W-1:0] HOLD_LAST    = HOLD_W'(MAX_HOLD - 1);
   localparam logic [HOLD_W-1:0] HOLD_SAT     = '1;

   logic              state_q, state_d;
   logic [1:0]        ptr_q, ptr_d;
   logic [1:0]        owner_q, owner_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [3:0]        gnt_q, gnt_d;
   logic              preempt_q, preempt_d;

   logic [3:0] req_vec;
   logic       pick_valid;
   logic [1:0] pick_idx;
   logic [1:0] scan_idx;

   assign req_vec = {req_3, req_2, req_1, req_0};

   // Scan from the highest offset down so the last hit is the one closest to ptr.
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = ptr_q;
      scan_idx   = ptr_q;
      for (int i = 3; i >= 0; i--) begin
         scan_idx = ptr_q + 2'(i);
         if (req_vec[scan_idx]) begin
            pick_valid = 1'b1;
            pick_idx   = scan_idx;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      owner_d   = owner_q;
      hold_d    = hold_q;
      gnt_d     = gnt_q;
      preempt_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            gnt_d = '0;
            if (pick_valid) begin
               owner_d = pick_idx;
               gnt_d   = 4'b0001 << pick_idx;
               hold_d  = '0;
               state_d = ST_GRANT;
            end
         end
         ST_GRANT: begin
            if (!req_vec[owner_q]) begin
               gnt_d   = '0;
               ptr_d   = owner_q + 2'd1;
               state_d = ST_IDLE;
            end else if (HOLD_LIMITED && (hold_q == HOLD_LAST)) begin
               // Moving ptr past the owner drops it to lowest priority next round.
               gnt_d     = '0;
               preempt_d = 1'b1;
               ptr_d     = owner_q + 2'd1;
               state_d   = ST_IDLE;
            end else if (hold_q != HOLD_SAT) begin
               hold_d = hold_q + 1'b1;
            end
         end
         default: begin
            gnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         ptr_q     <= '0;
         owner_q   <= '0;
         hold_q    <= '0;
         gnt_q     <= '0;
         preempt_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         owner_q   <= owner_d;
         hold_q    <= hold_d;
         gnt_q     <= gnt_d;
         preempt_q <= preempt_d;
      end
   end

   assign gnt_0     = gnt_q[0];
   assign gnt_1     = gnt_q[1];
   assign gnt_2     = gnt_q[2];
   assign gnt_3     = gnt_q[3];
   assign owner     = owner_q;
   assign busy      = |gnt_q;
   assign preempt   = preempt_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_fsm_rr_arbiter.sv
// Directed bench for fsm_rr_arbiter: one instance with MAX_HOLD=8, one with MAX_HOLD=0.
module tb_fsm_rr_arbiter;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] req_a = '0;
   logic [3:0] req_b = '0;

   logic       a_g0, a_g1, a_g2, a_g3, a_busy, a_pre, a_st;
   logic [1:0] a_own;
   logic       b_g0, b_g1, b_g2, b_g3, b_busy, b_pre, b_st;
   logic [1:0] b_own;

   int compared   = 0;
   int mismatched = 0;

   always #5 clock = ~clock;

   fsm_rr_arbiter #(.MAX_HOLD(8), .HOLD_W(4)) dut_a (
      .clock(clock), .reset(reset),
      .req_0(req_a[0]), .req_1(req_a[1]), .req_2(req_a[2]), .req_3(req_a[3]),
      .gnt_0(a_g0), .gnt_1(a_g1), .gnt_2(a_g2), .gnt_3(a_g3),
      .owner(a_own), .busy(a_busy), .preempt(a_pre), .dbg_state(a_st)
   );

   fsm_rr_arbiter #(.MAX_HOLD(0), .HOLD_W(4)) dut_b (
      .clock(clock), .reset(reset),
      .req_0(req_b[0]), .req_1(req_b[1]), .req_2(req_b[2]), .req_3(req_b[3]),
      .gnt_0(b_g0), .gnt_1(b_g1), .gnt_2(b_g2), .gnt_3(b_g3),
      .owner(b_own), .busy(b_busy), .preempt(b_pre), .dbg_state(b_st)
   );

   // Packed observation: {busy, preempt, owner[1:0], gnt[3:0]}
   function automatic logic [7:0] pk(input logic [3:0] g, input logic [1:0] o, input logic p);
      return {|g, p, o, g};
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      @(negedge clock);
   endtask

   task automatic check_a(input string tag, input logic [3:0] g, input logic [1:0] o, input logic p);
      logic [7:0] obs;
      logic [7:0] exp;
      obs = {a_busy, a_pre, a_own, a_g3, a_g2, a_g1, a_g0};
      exp = pk(g, o, p);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %b expected %b (busy,preempt,owner,gnt3..0)", tag, obs, exp);
      end
   endtask

   task automatic check_b(input string tag, input logic [3:0] g, input logic [1:0] o, input logic p);
      logic [7:0] obs;
      logic [7:0] exp;
      obs = {b_busy, b_pre, b_own, b_g3, b_g2, b_g1, b_g0};
      exp = pk(g, o, p);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %b expected %b (busy,preempt,owner,gnt3..0)", tag, obs, exp);
      end
   endtask

   initial begin
      logic [1:0] agent;

      // T1 reset held for two edges
      @(negedge clock);
      reset = 1'b1;
      step(2);
      check_a("t1_reset_a", 4'b0000, 2'd0, 1'b0);
      check_b("t1_reset_b", 4'b0000, 2'd0, 1'b0);
      reset = 1'b0;
      step(1);
      check_a("t1_idle", 4'b0000, 2'd0, 1'b0);

      // T2 single requester for 5 edges, then release
      req_a = 4'b0001;
      for (int i = 0; i < 5; i++) begin
         step(1);
         check_a($sformatf("t2_hold_%0d", i), 4'b0001, 2'd0, 1'b0);
      end
      req_a = 4'b0000;
      step(1);
      check_a("t2_release", 4'b0000, 2'd0, 1'b0);
      req_a = 4'b0011;
      step(1);
      check_a("t2_ptr1_req1_wins", 4'b0010, 2'd1, 1'b0);
      req_a = 4'b0000;
      step(1);
      check_a("t2_release1", 4'b0000, 2'd1, 1'b0);

      // T4 ptr=2 now; agent 0 tenure moves ptr to 1, then req_0/req_2 race
      req_a = 4'b0001;
      step(1);
      check_a("t4_grant0", 4'b0001, 2'd0, 1'b0);
      req_a = 4'b0000;
      step(1);
      check_a("t4_release0", 4'b0000, 2'd0, 1'b0);
      req_a = 4'b0101;
      step(1);
      check_a("t4_req2_first", 4'b0100, 2'd2, 1'b0);
      step(3);
      check_a("t4_req0_ignored", 4'b0100, 2'd2, 1'b0);
      req_a = 4'b0001;
      step(1);
      check_a("t4_gap", 4'b0000, 2'd2, 1'b0);
      step(1);
      check_a("t4_grant0_after_gap", 4'b0001, 2'd0, 1'b0);
      req_a = 4'b0000;
      step(1);
      check_a("t4_release", 4'b0000, 2'd0, 1'b0);

      // T3 saturation from ptr=0: order 0,1,2,3,0, 8 cycles each, preempt then gap
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      req_a = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         agent = 2'(k % 4);
         for (int c = 0; c < 8; c++) begin
            step(1);
            check_a($sformatf("t3_ten%0d_cyc%0d", k, c), 4'b0001 << agent, agent, 1'b0);
         end
         step(1);
         check_a($sformatf("t3_ten%0d_preempt", k), 4'b0000, agent, 1'b1);
      end

      // T5 ptr=1 after agent 0 preemption; get agent 3 then reset mid-grant
      req_a = 4'b1000;
      step(1);
      check_a("t5_grant3", 4'b1000, 2'd3, 1'b0);
      req_a = 4'b1010;
      reset = 1'b1;
      step(1);
      check_a("t5_reset_drops", 4'b0000, 2'd0, 1'b0);
      reset = 1'b0;
      step(1);
      check_a("t5_grant1_first", 4'b0010, 2'd1, 1'b0);
      req_a = 4'b0000;
      step(1);
      check_a("t5_release", 4'b0000, 2'd1, 1'b0);

      // T6 unlimited tenure: req_2 held 40 cycles on the MAX_HOLD=0 instance
      req_b = 4'b0100;
      for (int i = 0; i < 40; i++) begin
         step(1);
         check_b($sformatf("t6_hold_%0d", i), 4'b0100, 2'd2, 1'b0);
      end
      req_b = 4'b0000;
      step(1);
      check_b("t6_release", 4'b0000, 2'd2, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
